icache_fetch_arbiter: RTL
=========================

# icache_fetch_arbiter

Shares one instruction-cache request port between `NumReq` core instruction-fetch requesters within the RedMulE tile, using round-robin arbitration. It registers the winning request toward the I$ and holds it until the cache signals `ready`. It then routes the returning data and error back to the requester that owns the transfer. An optional watchdog ends a transfer the cache never completes and returns an error response instead.

## Interface
- `NumReq`, default 2: number of instruction-fetch requesters, at least 2.
- `TimeoutCycles`, default 0: number of BUSY cycles without `ready` before the transfer is aborted; 0 disables the watchdog.
- `CntW`, default `$clog2(TimeoutCycles+1)` (minimum 1): width of the watchdog counter.
- `clk_i`  in  1  clock; the block uses one clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `instr_req_i`  in  `NumReq` x `core_instr_req_t`  per-requester fields `req` and `addr`.
- `instr_rsp_o`  out  `NumReq` x `core_instr_rsp_t`  per-requester fields `gnt`, `rvalid`, `rdata` and `err`.
- `cache_req_o`  out  `core_cache_instr_req_t`  fields `valid`, `addr` and `cacheable`.
- `cache_rsp_i`  in  `core_cache_instr_rsp_t`  fields `ready`, `data` and `error`.
- `busy_o`  out  1  high while a transfer is in flight (state BUSY).
- `timeout_o`  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
- **States:** IDLE and BUSY.
- **IDLE arbitration:**
  - Round-robin over `instr_req_i[i].req`, starting the search at pointer `rr_q`.
  - The winner index goes to `owner_q` and its `addr` goes to `addr_q`.
  - The state moves to BUSY and the watchdog counter is cleared.
  - With no request pending, the block stays in IDLE.
- **BUSY:**
  - `cache_req_o.valid` = 1 and `cache_req_o.addr` = `addr_q`.
  - `cache_req_o.cacheable` is tied to 1.
- **BUSY with `cache_rsp_i.ready` = 1:**
  - `instr_rsp_o[owner_q]` gets `gnt` = 1, `rvalid` = 1, `rdata` = `cache_rsp_i.data` and `err` = `cache_rsp_i.error`.
  - `rr_q` moves to `(owner_q+1) mod NumReq` and the state returns to IDLE.
- **BUSY without `ready`:** the counter increments. When `TimeoutCycles` ≠ 0 and the counter equals `TimeoutCycles`:
  - The owner gets `gnt` = 1, `rvalid` = 1, `err` = 1 and `rdata` = 0.
  - `timeout_o` = 1 and `cache_req_o.valid` is deasserted in that same cycle.
  - `rr_q` advances and the state returns to IDLE.
- **Outputs to non-owners, and to all requesters in IDLE:** `gnt`, `rvalid` and `err` = 0, and `rdata` = 0.
- **Requester behaviour while BUSY:** requesters hold `req` and `addr` until they see `gnt`. If the owner drops `req`, the in-flight transfer still completes and the response is still delivered. A changed `addr` is ignored.
- **Address capture:** the captured address comes only from `addr_q`; the live requester address is never forwarded.

## Timing
- **Reset values:**
  - State IDLE, `rr_q` = 0, `owner_q` = 0, `addr_q` = 0 and counter = 0.
  - All `instr_rsp_o` fields 0.
  - `cache_req_o.valid` = 0, `cache_req_o.addr` = 0 and `cache_req_o.cacheable` = 1.
  - `busy_o` = 0 and `timeout_o` = 0.
- **Reset during BUSY:** the transfer is dropped with no response, and the next cycle shows reset values.
- **Latency:** a request seen in cycle T drives `cache_req_o.valid` in T+1. `gnt`/`rvalid` is combinational from `ready`, so the minimum is T+1 when the cache is ready immediately.
- **Throughput:** each transfer is followed by one mandatory IDLE cycle, so the maximum rate is one fetch per 2 cycles.
- **Simultaneous `ready` and timeout:** `ready` wins; the response is normal and `timeout_o` = 0.
- **Pointer wrap:** `rr_q` wraps from `NumReq-1` to 0.
- **Counter:** saturates and never wraps. With `TimeoutCycles` = 0 it is held at 0.

## Structure
- **Existing struct typedefs:** `core_instr_req_t`, `core_instr_rsp_t`, `core_cache_instr_req_t` and `core_cache_instr_rsp_t` stay in `redmule_tile_pkg`.
- **New package contents:** a state enum `icache_arb_state_e` {IDLE, BUSY} and a default constant `ICACHE_ARB_TIMEOUT`, both added to `redmule_tile_pkg`.
- **Sub-module:** `rr_arbiter_fixed`, a combinational round-robin priority selector that takes a request vector and a pointer and returns a one-hot grant plus an index. It is reusable by other tile arbiters.

## Test plan
- **Single requester, slow cache:** `NumReq` = 2, requester 0 fetches `addr` = 0x1000 and the cache asserts `ready` 3 cycles after `valid` with `data` = 0xDEADBEEF. Required: `cache_req_o.addr` = 0x1000 from T+1, and port 0 sees one cycle of `gnt`/`rvalid` with `rdata` = 0xDEADBEEF. Port 1 stays all 0.
- **Fairness, cache always ready:** both requesters hold `req` continuously, with `addr` 0x100 and 0x200. Required: grants alternate 0,1,0,1, the cache addresses alternate to match, and exactly one IDLE cycle separates transfers.
- **Watchdog abort:** `TimeoutCycles` = 4 and the cache never asserts `ready`. Required: after 4 BUSY cycles the owner gets `gnt`/`rvalid` with `err` = 1 and `rdata` = 0, `timeout_o` pulses for one cycle, and `valid` drops.
- **`ready` on the timeout cycle:** `TimeoutCycles` = 4 and `ready` arrives exactly at count 4. Required: a normal response with `err` = `cache_rsp_i.error`, and `timeout_o` = 0.
- **Mid-transfer requester changes:**
  - Required when the owner changes `addr` from 0x300 to 0x400 mid-BUSY: the cache still sees 0x300.
  - Required when the owner drops `req` before `ready`: the response is still delivered to port 0.
- **Reset during BUSY:** assert `rst_i` one cycle in. Required: next cycle shows `valid` = 0, no `gnt` is issued, and `rr_q` = 0, so requester 0 wins first afterwards.

Source files
------------

// File: rtl/redmule_tile_pkg.sv
// ---------------------------------------------------------------------------
// redmule_tile_pkg
// Shared tile types: core instruction-fetch request/response structs, the
// instruction-cache request/response structs, the fetch-arbiter state enum,
// the default watchdog length and a small round-robin pointer helper.
// ---------------------------------------------------------------------------
package redmule_tile_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Core-side instruction-fetch request
  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
  } core_instr_req_t;

  // Core-side instruction-fetch response
  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } core_instr_rsp_t;

  // Request toward the instruction cache
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              cacheable;
  } core_cache_instr_req_t;

  // Response from the instruction cache
  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              error;
  } core_cache_instr_rsp_t;

  // Fetch-arbiter control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } icache_arb_state_e;

  // Default watchdog length; zero leaves the watchdog disabled
  localparam int unsigned ICACHE_ARB_TIMEOUT = 32'd0;

  // Next round-robin start position after index idx, wrapping at n
  function automatic int unsigned rr_advance(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_fixed.sv
// ---------------------------------------------------------------------------
// rr_arbiter_fixed
// Combinational round-robin priority selector. The search starts at i_ptr and
// walks upward (wrapping) until it finds the first asserted request.
// Ports:
//   i_req   [N-1:0]    request vector
//   i_ptr   [IdxW-1:0] index with highest priority this cycle (must be < N)
//   o_gnt   [N-1:0]    one-hot grant (all zero when nothing requests)
//   o_idx   [IdxW-1:0] index of the granted request
//   o_valid            at least one request was found
// ---------------------------------------------------------------------------
module rr_arbiter_fixed #(
  parameter int N    = 2,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  // Priority search rotated by the pointer; first hit wins
  always_comb begin
    int cand;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[cand]) begin
        o_valid     = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = IdxW'(cand);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/icache_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// icache_fetch_arbiter
// Shares one instruction-cache port between NumReq fetch requesters with
// round-robin arbitration. The winning request is captured and presented to
// the cache until it is ready; data/error are routed back to the owner. An
// optional watchdog aborts a transfer the cache never completes.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   instr_req_i  per-requester req/addr
//   instr_rsp_o  per-requester gnt/rvalid/rdata/err (gnt and rvalid together)
//   cache_req_o  valid/addr/cacheable toward the I$
//   cache_rsp_i  ready/data/error from the I$
//   busy_o       a transfer is in flight
//   timeout_o    one-cycle pulse when the watchdog aborts a transfer
// ---------------------------------------------------------------------------
module icache_fetch_arbiter
  import redmule_tile_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = int'(ICACHE_ARB_TIMEOUT),
  parameter int CntW          = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  core_instr_req_t       instr_req_i [NumReq],
  output core_instr_rsp_t       instr_rsp_o [NumReq],
  output core_cache_instr_req_t cache_req_o,
  input  core_cache_instr_rsp_t cache_rsp_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  icache_arb_state_e r_state;
  icache_arb_state_e w_state_next;
  logic [IdxW-1:0]   r_rr;
  logic [IdxW-1:0]   w_rr_next;
  logic [IdxW-1:0]   r_owner;
  logic [IdxW-1:0]   w_owner_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;

  logic [NumReq-1:0] w_req_vec;
  logic [NumReq-1:0] w_arb_gnt;
  logic [IdxW-1:0]   w_arb_idx;
  logic              w_arb_valid;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_timeout_hit;

  // Gather the request bits and the winner's address via the one-hot grant
  always_comb begin
    w_req_vec  = '0;
    w_win_addr = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_req_vec[i] = instr_req_i[i].req;
      if (w_arb_gnt[i]) begin
        w_win_addr = w_win_addr | instr_req_i[i].addr;
      end else begin
        w_win_addr = w_win_addr;
      end
    end
  end

  rr_arbiter_fixed #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .i_req   (w_req_vec),
    .i_ptr   (r_rr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Watchdog limit reached; a zero limit never fires
  assign w_timeout_hit = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles));

  // Next-state and output decode; reset cycle suppresses every response
  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr;
    w_owner_next = r_owner;
    w_addr_next  = r_addr;
    w_cnt_next   = r_cnt;
    for (int i = 0; i < NumReq; i++) begin
      instr_rsp_o[i] = '0;
    end
    cache_req_o.valid     = 1'b0;
    cache_req_o.addr      = '0;
    cache_req_o.cacheable = 1'b1;
    busy_o                = 1'b0;
    timeout_o             = 1'b0;

    if (rst_i) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            w_state_next = BUSY;
            w_owner_next = w_arb_idx;
            w_addr_next  = w_win_addr;
            w_cnt_next   = '0;
          end else begin
            w_state_next = IDLE;
          end
        end
        BUSY: begin
          busy_o            = 1'b1;
          cache_req_o.valid = 1'b1;
          cache_req_o.addr  = r_addr;
          // ready takes precedence over a simultaneous watchdog expiry
          if (cache_rsp_i.ready) begin
            instr_rsp_o[r_owner].gnt    = 1'b1;
            instr_rsp_o[r_owner].rvalid = 1'b1;
            instr_rsp_o[r_owner].rdata  = cache_rsp_i.data;
            instr_rsp_o[r_owner].err    = cache_rsp_i.error;
            w_rr_next    = IdxW'(rr_advance(32'(r_owner), 32'(NumReq)));
            w_state_next = IDLE;
          end else if (w_timeout_hit) begin
            instr_rsp_o[r_owner].gnt    = 1'b1;
            instr_rsp_o[r_owner].rvalid = 1'b1;
            instr_rsp_o[r_owner].err    = 1'b1;
            cache_req_o.valid = 1'b0;
            timeout_o         = 1'b1;
            w_rr_next    = IdxW'(rr_advance(32'(r_owner), 32'(NumReq)));
            w_state_next = IDLE;
          end else if (TimeoutCycles == 0) begin
            w_cnt_next = '0;
          end else if (r_cnt != {CntW{1'b1}}) begin
            w_cnt_next = r_cnt + CntW'(1);
          end else begin
            w_cnt_next = r_cnt;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // State, pointer, capture and watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rr    <= w_rr_next;
      r_owner <= w_owner_next;
      r_addr  <= w_addr_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule
